// File: rtl/fft_pair_former.sv
// rtl/fft_pair_former.sv - streaming x[n] / x[n+D] pair former for a radix-2 FFT stage
//
// Purpose: buffers the first half (D samples) of every 2*D-sample block and,
// while the second half streams in, presents each new sample together with
// the buffered sample D positions earlier, one registered pair per cycle.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   data_in        serial complex sample {re, im}, 2*float_len bits
//   data_in_valid  data_in is valid this cycle
//   data_in_sof    first sample of a frame (qualified by data_in_valid)
//   data_out1      pair upper operand x[n]
//   data_out2      pair lower operand x[n+D]
//   data_out_valid pair valid, one cycle per second-half sample
//   data_out_idx   n mod D of the current pair (twiddle address)
//   sof_err        sticky: a frame restarted in the middle of a block
module fft_pair_former #(
  parameter int float_len = 20,
  parameter int dist_len  = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*float_len-1:0] data_in,
  input  logic                   data_in_valid,
  input  logic                   data_in_sof,
  output logic [2*float_len-1:0] data_out1,
  output logic [2*float_len-1:0] data_out2,
  output logic                   data_out_valid,
  output logic [dist_len-1:0]    data_out_idx,
  output logic                   sof_err
);

  localparam int W = 2 * float_len;
  localparam int D = 1 << dist_len;

  // First-half buffer; no reset so it maps onto block RAM.
  logic [W-1:0]        r_mem [D];

  logic [dist_len:0]   r_cnt;
  logic [W-1:0]        r_out1;
  logic [W-1:0]        r_out2;
  logic [dist_len-1:0] r_idx;
  logic                r_valid;
  logic                r_err;

  logic                w_accept;
  logic                w_pair_phase;
  logic [dist_len-1:0] w_addr;
  logic                w_wr_en;
  logic [dist_len-1:0] w_wr_addr;

  assign w_accept     = data_in_valid && !rst;
  assign w_pair_phase = r_cnt[dist_len];
  assign w_addr       = r_cnt[dist_len-1:0];

  // A start-of-frame sample is always index 0 and therefore a FILL write,
  // regardless of where the counter currently sits.
  assign w_wr_en   = w_accept && (data_in_sof || !w_pair_phase);
  assign w_wr_addr = data_in_sof ? '0 : w_addr;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_out1  <= '0;
      r_out2  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (data_in_valid) begin
        if (data_in_sof) begin
          // Restarting a frame abandons any partial block; its pairs are lost.
          if (r_cnt != '0) begin
            r_err <= 1'b1;
          end
          r_cnt <= {{dist_len{1'b0}}, 1'b1};
        end else begin
          r_cnt <= r_cnt + 1'b1;  // natural wrap from 2*D-1 to 0
          if (w_pair_phase) begin
            // Synchronous read: the memory output register is data_out1.
            // The address being read was written during FILL, never now.
            r_out1  <= r_mem[w_addr];
            r_out2  <= data_in;
            r_idx   <= w_addr;
            r_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign data_out1      = r_out1;
  assign data_out2      = r_out2;
  assign data_out_idx   = r_idx;
  assign data_out_valid = r_valid;
  assign sof_err        = r_err;

endmodule
